// File: rtl/mesi_isc_pkg.sv
// Shared definitions for the MESI snoop-broadcast path: field widths and the
// packed broadcast entry used by the broadcast FIFO and its controller.
package mesi_isc_pkg;

  localparam int BROAD_TYPE_WIDTH   = 2;
  localparam int BROAD_CPU_ID_WIDTH = 2;
  localparam int BROAD_ID_WIDTH     = 5;

  typedef struct packed {
    logic [BROAD_TYPE_WIDTH-1:0]   snoop_type;
    logic [BROAD_CPU_ID_WIDTH-1:0] cpu_id;
    logic [BROAD_ID_WIDTH-1:0]     id;
  } broad_entry_t;

  localparam int BROAD_ENTRY_WIDTH = $bits(broad_entry_t);

endpackage

// File: rtl/mesi_isc_broad_fifo.sv
// Show-ahead FIFO holding snoop broadcasts between the main-bus arbiter and the
// broadcast controller, with sticky overflow/underflow flags.
module mesi_isc_broad_fifo
  import mesi_isc_pkg::*;
#(
  parameter int DATA_WIDTH      = BROAD_ENTRY_WIDTH,
  parameter int FIFO_DEPTH      = 4,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_i,
  input  logic [DATA_WIDTH-1:0]    data_i,
  input  logic                     rd_i,
  output logic [DATA_WIDTH-1:0]    data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [FIFO_DEPTH_LOG2:0] count_o,
  output logic                     overflow_o,
  output logic                     underflow_o
);

  typedef logic [FIFO_DEPTH_LOG2-1:0] ptr_t;
  typedef logic [FIFO_DEPTH_LOG2:0]   cnt_t;

  localparam cnt_t FULL_COUNT = cnt_t'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  ptr_t wr_ptr;
  ptr_t rd_ptr;
  logic push;
  logic pop;

  assign empty_o = (count_o == '0);
  assign full_o  = (count_o == FULL_COUNT);

  // A full FIFO still accepts a write when the head is leaving in the same cycle.
  assign push = wr_i && (!full_o || rd_i);
  assign pop  = rd_i && !empty_o;

  assign data_o = empty_o ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_o     <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ptr_t'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ptr_t'(1);
      end
      if (push && !pop) begin
        count_o <= count_o + cnt_t'(1);
      end else if (pop && !push) begin
        count_o <= count_o - cnt_t'(1);
      end
      if (wr_i && !push) begin
        overflow_o <= 1'b1;
      end
      if (rd_i && empty_o) begin
        underflow_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mesi_isc_broad_fifo.sv
// Scoreboard bench for the broadcast FIFO: a queue model tracks expected
// contents, flags and count, and every popped entry is compared in order.
module tb_mesi_isc_broad_fifo;

  localparam int DW    = 9;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst;
  logic          wr_i;
  logic [DW-1:0] data_i;
  logic          rd_i;
  logic [DW-1:0] data_o;
  logic          empty_o;
  logic          full_o;
  logic [2:0]    count_o;
  logic          overflow_o;
  logic          underflow_o;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] sb [$];
  logic          ovf_model;
  logic          udf_model;

  mesi_isc_broad_fifo #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .FIFO_DEPTH_LOG2(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_i(wr_i),
    .data_i(data_i),
    .rd_i(rd_i),
    .data_o(data_o),
    .empty_o(empty_o),
    .full_o(full_o),
    .count_o(count_o),
    .overflow_o(overflow_o),
    .underflow_o(underflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic checkState(input string tag);
    logic [DW-1:0] head;
    head = (sb.size() != 0) ? sb[0] : '0;
    checkOutput({tag, ".count"}, 32'(count_o), 32'(sb.size()));
    checkOutput({tag, ".empty"}, 32'(empty_o), 32'(sb.size() == 0));
    checkOutput({tag, ".full"}, 32'(full_o), 32'(sb.size() == DEPTH));
    checkOutput({tag, ".data"}, 32'(data_o), 32'(head));
    checkOutput({tag, ".ovf"}, 32'(overflow_o), 32'(ovf_model));
    checkOutput({tag, ".udf"}, 32'(underflow_o), 32'(udf_model));
  endtask

  // Called just after a rising edge; drives one cycle of wr/rd and updates the model.
  task automatic applyStimulus(input string tag, input logic wr, input logic rd,
                               input logic [DW-1:0] data);
    logic push;
    logic pop;
    logic [DW-1:0] expd;
    wr_i   = wr;
    rd_i   = rd;
    data_i = data;
    push = wr && ((sb.size() < DEPTH) || rd);
    pop  = rd && (sb.size() != 0);
    @(negedge clk);
    if (pop) begin
      checkOutput({tag, ".pop"}, 32'(data_o), 32'(sb[0]));
    end
    @(posedge clk);
    #1;
    if (pop) begin
      expd = sb.pop_front();
    end
    if (push) begin
      sb.push_back(data);
    end
    if (wr && !push) ovf_model = 1'b1;
    if (rd && !pop) udf_model = 1'b1;
    wr_i = 1'b0;
    rd_i = 1'b0;
    checkState(tag);
  endtask

  initial begin
    rst       = 1'b0;
    wr_i      = 1'b0;
    rd_i      = 1'b0;
    data_i    = '0;
    ovf_model = 1'b0;
    udf_model = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkState("reset");

    applyStimulus("push1a5", 1'b1, 1'b0, 9'h1A5);
    applyStimulus("pop1a5", 1'b0, 1'b1, 9'h000);

    for (int i = 1; i <= 4; i++) applyStimulus("fill", 1'b1, 1'b0, 9'(i));
    for (int i = 0; i < 4; i++) applyStimulus("drain", 1'b0, 1'b1, 9'h000);

    for (int i = 1; i <= 4; i++) applyStimulus("fill2", 1'b1, 1'b0, 9'(9'h010 + i));
    applyStimulus("ovf", 1'b1, 1'b0, 9'h0FF);
    applyStimulus("fullrw", 1'b1, 1'b1, 9'h155);
    for (int i = 0; i < 4; i++) applyStimulus("drain2", 1'b0, 1'b1, 9'h000);

    applyStimulus("udf", 1'b0, 1'b1, 9'h000);
    applyStimulus("wrapfill", 1'b1, 1'b0, 9'h0C0);
    for (int i = 0; i < 10; i++) applyStimulus("wrap", 1'b1, 1'b1, 9'(9'h0C1 + i));
    applyStimulus("wrapdrain", 1'b0, 1'b1, 9'h000);

    for (int i = 0; i < 40; i++) begin
      applyStimulus("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    9'($urandom));
    end
    while (sb.size() != 0) applyStimulus("flush", 1'b0, 1'b1, 9'h000);

    for (int i = 0; i < 3; i++) applyStimulus("pre_rst", 1'b1, 1'b0, 9'(9'h0A0 + i));
    #2;
    rst = 1'b0;
    #1;
    sb.delete();
    ovf_model = 1'b0;
    udf_model = 1'b0;
    checkState("async_rst");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkState("post_rst");
    applyStimulus("push_after_rst", 1'b1, 1'b0, 9'h0AB);
    applyStimulus("pop_after_rst", 1'b0, 1'b1, 9'h000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
